// File: rtl/e_mdu_pkg.sv
// Purpose: shared op codes, default busy periods and the HI/LO pair type for the E-stage MDU.
// Latency: n/a (declarations only).
// Backpressure: n/a; stalling is done by hazard control through e_mdu busy.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // HI occupies the upper half so a 64-bit product maps straight onto it.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Codes 1..4 are the only ones that start a multi-cycle operation.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= 4'(MDU_MULT)) && (op <= 4'(MDU_DIVU));
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Purpose: E-stage <-> MDU bundle: op request, operands, busy and the HI/LO/read-back values.
// Latency: n/a (wiring only).
// Backpressure: busy tells the pipeline to stall HI/LO-dependent instructions.
// Ports: start/mdu_op/A/B driven by the pipeline (master); busy/HI/LO/rd_out driven by the MDU (slave).
interface e_mdu_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] rd_out;

  modport master (output start, mdu_op, A, B, input busy, HI, LO, rd_out);
  modport slave  (input start, mdu_op, A, B, output busy, HI, LO, rd_out);
endinterface

// File: rtl/e_mdu_calc.sv
// Purpose: combinational 64-bit product / quotient+remainder for mult, multu, div, divu.
// Latency: 0 cycles (pure logic, result latched by e_mdu at the start edge).
// Backpressure: none.
// Ports: op/a/b in; res = {hi,lo} result, div_zero flags a zero divisor.
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output hilo_t       res,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sgn;
  logic        ovf;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] dvs;
  logic [31:0] q;
  logic [31:0] r;

  always_comb begin
    prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u   = {32'b0, a} * {32'b0, b};
    sgn      = (op == 4'(MDU_DIV));
    // One unsigned divider serves both flavours; signed div works on magnitudes.
    abs_a    = (sgn && a[31]) ? -a : a;
    abs_b    = (sgn && b[31]) ? -b : b;
    div_zero = (b == 32'd0);
    // Keep the divider defined for b==0; its output is discarded in that case.
    dvs      = div_zero ? 32'd1 : abs_b;
    q        = abs_a / dvs;
    r        = abs_a % dvs;
    ovf      = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    res      = '0;
    case (op)
      4'(MDU_MULT):  res = hilo_t'(prod_s);
      4'(MDU_MULTU): res = hilo_t'(prod_u);
      4'(MDU_DIV): begin
        if (ovf) begin
          res.hi = 32'd0;
          res.lo = 32'h8000_0000;
        end else begin
          res.lo = (a[31] ^ b[31]) ? -q : q;
          res.hi = a[31] ? -r : r;
        end
      end
      4'(MDU_DIVU): begin
        res.hi = r;
        res.lo = q;
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Purpose: E-stage multiply/divide unit owning architectural HI/LO.
// Latency: HI/LO update MULT_CYCLES / DIV_CYCLES edges after the start edge; rd_out is combinational.
// Backpressure: busy is high while an operation is in flight; new starts and mthi/mtlo are ignored then.
// Ports: clk, reset (async active-low), bus (e_mdu_if slave: start, mdu_op, A, B -> busy, HI, LO, rd_out).
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic     clk,
  input  logic     reset,
  e_mdu_if.slave   bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  hilo_t            tmp_q;
  logic             tmp_wr_q;   // cleared for a zero-divide so HI/LO stay put
  hilo_t            calc_res;
  logic             calc_div_zero;

  e_mdu_calc u_calc (
    .op       (bus.mdu_op),
    .a        (bus.A),
    .b        (bus.B),
    .res      (calc_res),
    .div_zero (calc_div_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_q    <= '0;
      tmp_wr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && is_md_op(bus.mdu_op)) begin
            state    <= RUN;
            tmp_q    <= calc_res;
            tmp_wr_q <= !(calc_div_zero &&
                          (bus.mdu_op == 4'(MDU_DIV) || bus.mdu_op == 4'(MDU_DIVU)));
            cnt      <= (bus.mdu_op == 4'(MDU_MULT) || bus.mdu_op == 4'(MDU_MULTU))
                        ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
          end else if (!bus.start && bus.mdu_op == 4'(MDU_MTHI)) begin
            hi_q <= bus.A;
          end else if (!bus.start && bus.mdu_op == 4'(MDU_MTLO)) begin
            lo_q <= bus.A;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state <= IDLE;
            if (tmp_wr_q) begin
              hi_q <= tmp_q.hi;
              lo_q <= tmp_q.lo;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  // Architectural registers only; the in-flight result is never forwarded.
  assign bus.rd_out = (bus.mdu_op == 4'(MDU_MFHI)) ? hi_q :
                      (bus.mdu_op == 4'(MDU_MFLO)) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Purpose: self-checking bench for e_mdu: directed plan cases plus randomized ops vs. an arithmetic model.
// Latency: checks busy for exactly N cycles after each start edge and HI/LO in the cycle busy falls.
// Backpressure: exercises ignored starts and mthi while busy.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result {hi,lo} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] cur_hi,
                                              input logic [31:0] cur_lo);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = {cur_hi, cur_lo};
    case (op)
      4'd1: p = sa * sb;
      4'd2: p = ua * ub;
      4'd3: if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        p  = {sr[31:0], sq[31:0]};
      end
      4'd4: if (b != 0) begin
        uq = ua / ub;
        ur = ua % ub;
        p  = {ur[31:0], uq[31:0]};
      end
      default: p = {cur_hi, cur_lo};
    endcase
    return p;
  endfunction

  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit intrude, input string tag);
    int n;
    logic [63:0] exp;
    n   = (op == 4'(MDU_MULT) || op == 4'(MDU_MULTU)) ? MULT_N : DIV_N;
    exp = ref_result(op, a, b, m_hi, m_lo);
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = op; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mdu_op = 4'(MDU_NONE); bus.A = $urandom; bus.B = $urandom;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
      chk({tag, "_hi_hold"}, bus.HI, m_hi);
      chk({tag, "_lo_hold"}, bus.LO, m_lo);
      if (intrude && i == 0) begin
        bus.start = 1'b1; bus.mdu_op = 4'(MDU_DIV); bus.A = $urandom; bus.B = $urandom;
      end else if (intrude && i == 1) begin
        bus.start = 1'b0; bus.mdu_op = 4'(MDU_MTHI); bus.A = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0; bus.mdu_op = 4'(MDU_NONE);
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.mdu_op = 4'(MDU_NONE);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    chk({tag, "_done_busy"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, "_hi"}, bus.HI, m_hi);
    chk({tag, "_lo"}, bus.LO, m_lo);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    bus.start = 1'b0; bus.mdu_op = op; bus.A = v;
    @(posedge clk); #1;
    bus.mdu_op = 4'(MDU_NONE);
    if (op == 4'(MDU_MTHI)) m_hi = v; else m_lo = v;
    chk("mt_hi", bus.HI, m_hi);
    chk("mt_lo", bus.LO, m_lo);
  endtask

  task automatic rd_chk();
    @(negedge clk);
    bus.mdu_op = 4'(MDU_MFHI); #1;
    chk("rd_mfhi", bus.rd_out, m_hi);
    bus.mdu_op = 4'(MDU_MFLO); #1;
    chk("rd_mflo", bus.rd_out, m_lo);
    bus.mdu_op = 4'(MDU_NONE); #1;
    chk("rd_none", bus.rd_out, 32'd0);
    bus.mdu_op = 4'd12; #1;
    chk("rd_op12", bus.rd_out, 32'd0);
    bus.mdu_op = 4'(MDU_NONE);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    m_hi = '0; m_lo = '0;
    reset = 1'b0;
    bus.start = 1'b0; bus.mdu_op = 4'(MDU_NONE); bus.A = '0; bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    @(negedge clk); reset = 1'b1;

    run_md(4'(MDU_MULT), 32'hFFFF_FFFE, 32'd3, 1'b0, "mult");
    chk("mult_hi_lit", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo_lit", bus.LO, 32'hFFFF_FFFA);
    rd_chk();

    run_md(4'(MDU_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu");
    chk("multu_hi_lit", bus.HI, 32'hFFFF_FFFE);
    chk("multu_lo_lit", bus.LO, 32'h0000_0001);

    run_md(4'(MDU_DIV), 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
    chk("div_lo_lit", bus.LO, 32'hFFFF_FFFD);
    chk("div_hi_lit", bus.HI, 32'hFFFF_FFFF);

    mt(4'(MDU_MTHI), 32'h1234_5678);
    mt(4'(MDU_MTLO), 32'h9ABC_DEF0);
    run_md(4'(MDU_DIVU), 32'd7, 32'd0, 1'b0, "divu_z");
    chk("divu_z_hi_lit", bus.HI, 32'h1234_5678);
    chk("divu_z_lo_lit", bus.LO, 32'h9ABC_DEF0);
    rd_chk();

    run_md(4'(MDU_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    chk("div_ovf_lo_lit", bus.LO, 32'h8000_0000);
    chk("div_ovf_hi_lit", bus.HI, 32'h0000_0000);

    // start paired with a non-md op must neither start nor write HI.
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 4'(MDU_MTHI); bus.A = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mdu_op = 4'(MDU_NONE);
    chk("bad_start_busy", {31'b0, bus.busy}, 32'd0);
    chk("bad_start_hi", bus.HI, m_hi);

    // Second start and mthi while busy are ignored.
    run_md(4'(MDU_MULT), 32'd7, 32'd9, 1'b1, "intrude");
    chk("intrude_lo_lit", bus.LO, 32'd63);

    // Asynchronous reset in the middle of a run.
    mt(4'(MDU_MTHI), 32'hCAFE_0001);
    @(negedge clk);
    bus.start = 1'b1; bus.mdu_op = 4'(MDU_MULT); bus.A = 32'd5; bus.B = 32'd6;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mdu_op = 4'(MDU_NONE);
    @(posedge clk); #2;
    reset = 1'b0; #1;
    m_hi = '0; m_lo = '0;
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_hi", bus.HI, 32'd0);
    chk("arst_lo", bus.LO, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (MULT_N + 1) begin
      @(posedge clk); #1;
      chk("post_rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("post_rst_lo", bus.LO, 32'd0);
    end

    for (int k = 0; k < 24; k++) begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 4'(1 + $urandom_range(3));
      a  = $urandom;
      case ($urandom_range(5))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = $urandom >> $urandom_range(31);
        default: b = $urandom;
      endcase
      if (k % 4 == 3) begin
        mt(($urandom_range(1) == 0) ? 4'(MDU_MTHI) : 4'(MDU_MTLO), $urandom);
      end
      run_md(op, a, b, ($urandom_range(3) == 0), "rand");
      if (k % 6 == 5) rd_chk();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
